// File: rtl/sprite_engine.sv
// Bouncing square sprite for a VGA pixel pipeline: moves once per frame,
// recolours on every wall bounce, and renders one registered pixel per clock.
module sprite_engine #(
    parameter int unsigned H_ACTIVE = 1440,
    parameter int unsigned V_ACTIVE = 900,
    parameter int unsigned SIZE     = 64,
    parameter int unsigned STEP     = 4,
    parameter int unsigned INIT_X   = 520,
    parameter int unsigned INIT_Y   = 300
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] curr_x,
    input  logic [10:0] curr_y,
    input  logic        pause,
    output logic [3:0]  draw_r,
    output logic [3:0]  draw_g,
    output logic [3:0]  draw_b,
    output logic        frame_tick,
    output logic [7:0]  bounce_count
);

    localparam int unsigned CW = 11;
    localparam int unsigned PW = CW + 1;
    localparam int unsigned BW = 8;

    localparam logic [PW-1:0] X_LIMIT = PW'(H_ACTIVE);
    localparam logic [PW-1:0] Y_LIMIT = PW'(V_ACTIVE);
    localparam logic [PW-1:0] REACH   = PW'(SIZE + STEP);
    localparam logic [PW-1:0] EXTENT  = PW'(SIZE);
    localparam logic [CW-1:0] X_MAX   = CW'(H_ACTIVE - SIZE);
    localparam logic [CW-1:0] Y_MAX   = CW'(V_ACTIVE - SIZE);
    localparam logic [CW-1:0] STEP_C  = CW'(STEP);
    localparam logic [CW-1:0] INIT_XC = CW'(INIT_X);
    localparam logic [CW-1:0] INIT_YC = CW'(INIT_Y);
    localparam logic [CW-1:0] TICK_Y  = CW'(V_ACTIVE);

    logic [CW-1:0] r_pos_x;
    logic [CW-1:0] r_pos_y;
    logic          r_dx;
    logic          r_dy;
    logic [1:0]    r_palette;
    logic [BW-1:0] r_bounce;
    logic          r_frame_tick;
    logic          r_pause_meta;
    logic          r_pause_sync;
    logic [3:0]    r_draw_r;
    logic [3:0]    r_draw_g;
    logic [3:0]    r_draw_b;

    logic          w_tick;
    logic          w_update;
    logic [CW-1:0] w_pos_x_nxt;
    logic [CW-1:0] w_pos_y_nxt;
    logic          w_dx_nxt;
    logic          w_dy_nxt;
    logic          w_x_hit;
    logic          w_y_hit;
    logic [PW-1:0] w_x_end;
    logic [PW-1:0] w_y_end;
    logic          w_inside;
    logic [3:0]    w_pal_r;
    logic [3:0]    w_pal_g;
    logic [3:0]    w_pal_b;

    assign w_tick   = (curr_x == '0) && (curr_y == TICK_Y);
    assign w_update = w_tick && !r_pause_sync;

    // Next position/direction for each axis; a wall hit clamps to the wall and reverses
    always_comb begin
        w_pos_x_nxt = r_pos_x;
        w_dx_nxt    = r_dx;
        w_x_hit     = 1'b0;
        w_pos_y_nxt = r_pos_y;
        w_dy_nxt    = r_dy;
        w_y_hit     = 1'b0;

        if (r_dx) begin
            if (({1'b0, r_pos_x} + REACH) >= X_LIMIT) begin
                w_pos_x_nxt = X_MAX;
                w_dx_nxt    = 1'b0;
                w_x_hit     = 1'b1;
            end else begin
                w_pos_x_nxt = r_pos_x + STEP_C;
            end
        end else if (r_pos_x <= STEP_C) begin
            w_pos_x_nxt = '0;
            w_dx_nxt    = 1'b1;
            w_x_hit     = 1'b1;
        end else begin
            w_pos_x_nxt = r_pos_x - STEP_C;
        end

        if (r_dy) begin
            if (({1'b0, r_pos_y} + REACH) >= Y_LIMIT) begin
                w_pos_y_nxt = Y_MAX;
                w_dy_nxt    = 1'b0;
                w_y_hit     = 1'b1;
            end else begin
                w_pos_y_nxt = r_pos_y + STEP_C;
            end
        end else if (r_pos_y <= STEP_C) begin
            w_pos_y_nxt = '0;
            w_dy_nxt    = 1'b1;
            w_y_hit     = 1'b1;
        end else begin
            w_pos_y_nxt = r_pos_y - STEP_C;
        end
    end

    // One extra bit on the far edge so pos+SIZE never wraps
    assign w_x_end  = {1'b0, r_pos_x} + EXTENT;
    assign w_y_end  = {1'b0, r_pos_y} + EXTENT;
    assign w_inside = ({1'b0, curr_x} >= {1'b0, r_pos_x}) && ({1'b0, curr_x} < w_x_end) &&
                      ({1'b0, curr_y} >= {1'b0, r_pos_y}) && ({1'b0, curr_y} < w_y_end);

    always_comb begin
        w_pal_r = 4'hF;
        w_pal_g = 4'hF;
        w_pal_b = 4'hF;
        case (r_palette)
            2'd1:    begin w_pal_r = 4'hF; w_pal_g = 4'h0; w_pal_b = 4'h0; end
            2'd2:    begin w_pal_r = 4'h0; w_pal_g = 4'hF; w_pal_b = 4'h0; end
            2'd3:    begin w_pal_r = 4'h0; w_pal_g = 4'h0; w_pal_b = 4'hF; end
            default: begin w_pal_r = 4'hF; w_pal_g = 4'hF; w_pal_b = 4'hF; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pos_x      <= INIT_XC;
            r_pos_y      <= INIT_YC;
            r_dx         <= 1'b1;
            r_dy         <= 1'b1;
            r_palette    <= 2'd0;
            r_bounce     <= '0;
            r_frame_tick <= 1'b0;
            r_pause_meta <= 1'b0;
            r_pause_sync <= 1'b0;
            r_draw_r     <= '0;
            r_draw_g     <= '0;
            r_draw_b     <= '0;
        end else begin
            r_pause_meta <= pause;
            r_pause_sync <= r_pause_meta;
            r_frame_tick <= w_tick;
            if (w_update) begin
                r_pos_x <= w_pos_x_nxt;
                r_pos_y <= w_pos_y_nxt;
                r_dx    <= w_dx_nxt;
                r_dy    <= w_dy_nxt;
                // A corner hit is a single bounce event
                if (w_x_hit || w_y_hit) begin
                    r_palette <= r_palette + 2'd1;
                    r_bounce  <= r_bounce + BW'(1);
                end
            end
            r_draw_r <= w_inside ? w_pal_r : 4'h0;
            r_draw_g <= w_inside ? w_pal_g : 4'h0;
            r_draw_b <= w_inside ? w_pal_b : 4'h0;
        end
    end

    assign draw_r       = r_draw_r;
    assign draw_g       = r_draw_g;
    assign draw_b       = r_draw_b;
    assign frame_tick   = r_frame_tick;
    assign bounce_count = r_bounce;

endmodule

// File: tb/tb_sprite_engine.sv
// Directed bench for sprite_engine: three instances cover default motion,
// a right-wall bounce start point, and a tiny screen that forces corner hits.
module tb_sprite_engine;

    logic        clk = 1'b0;
    logic        rst_n_m;
    logic        rst_n_e;
    logic        rst_n_c;
    logic [10:0] curr_x;
    logic [10:0] curr_y;
    logic        pause;

    logic [3:0]  m_r, m_g, m_b, e_r, e_g, e_b, c_r, c_g, c_b;
    logic        m_tick, e_tick, c_tick;
    logic [7:0]  m_bc, e_bc, c_bc;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    sprite_engine dut_m (
        .clk(clk), .rst_n(rst_n_m), .curr_x(curr_x), .curr_y(curr_y), .pause(pause),
        .draw_r(m_r), .draw_g(m_g), .draw_b(m_b), .frame_tick(m_tick), .bounce_count(m_bc)
    );

    sprite_engine #(.INIT_X(1374)) dut_e (
        .clk(clk), .rst_n(rst_n_e), .curr_x(curr_x), .curr_y(curr_y), .pause(pause),
        .draw_r(e_r), .draw_g(e_g), .draw_b(e_b), .frame_tick(e_tick), .bounce_count(e_bc)
    );

    sprite_engine #(.H_ACTIVE(70), .V_ACTIVE(71), .INIT_X(2), .INIT_Y(3)) dut_c (
        .clk(clk), .rst_n(rst_n_c), .curr_x(curr_x), .curr_y(curr_y), .pause(pause),
        .draw_r(c_r), .draw_g(c_g), .draw_b(c_b), .frame_tick(c_tick), .bounce_count(c_bc)
    );

    task automatic step(input logic [10:0] x, input logic [10:0] y);
        curr_x = x;
        curr_y = y;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n_m = 1'b0; rst_n_e = 1'b0; rst_n_c = 1'b0; pause = 1'b0;
        step(11'd100, 11'd100);
        step(11'd100, 11'd100);
        step(11'd0, 11'd900);
        n_cmp++; if (m_tick !== 1'b0) begin n_mis++; $display("FAIL reset_tick: got %b expected 0", m_tick); end
        n_cmp++; if (m_bc !== 8'd0) begin n_mis++; $display("FAIL reset_bounce: got %0d expected 0", m_bc); end
        n_cmp++; if ({m_r, m_g, m_b} !== 12'h000) begin n_mis++; $display("FAIL reset_draw: got %h expected 000", {m_r, m_g, m_b}); end
        n_cmp++; if ({dut_m.r_pos_x, dut_m.r_pos_y} !== {11'd520, 11'd300}) begin
            n_mis++; $display("FAIL reset_pos: got (%0d,%0d) expected (520,300)", dut_m.r_pos_x, dut_m.r_pos_y); end
        n_cmp++; if ({dut_m.r_dx, dut_m.r_dy, dut_m.r_palette} !== 4'b1100) begin
            n_mis++; $display("FAIL reset_dir_pal: got %b expected 1100", {dut_m.r_dx, dut_m.r_dy, dut_m.r_palette}); end
    endtask

    task automatic test_first_tick();
        rst_n_m = 1'b1;
        step(11'd5, 11'd5);
        n_cmp++; if (m_tick !== 1'b0) begin n_mis++; $display("FAIL pre_tick: got %b expected 0", m_tick); end
        n_cmp++; if ({dut_m.r_pos_x, dut_m.r_pos_y} !== {11'd520, 11'd300}) begin
            n_mis++; $display("FAIL pre_tick_pos: got (%0d,%0d) expected (520,300)", dut_m.r_pos_x, dut_m.r_pos_y); end
        step(11'd0, 11'd900);
        n_cmp++; if (m_tick !== 1'b1) begin n_mis++; $display("FAIL first_tick: got %b expected 1", m_tick); end
        n_cmp++; if ({dut_m.r_pos_x, dut_m.r_pos_y} !== {11'd524, 11'd304}) begin
            n_mis++; $display("FAIL first_pos: got (%0d,%0d) expected (524,304)", dut_m.r_pos_x, dut_m.r_pos_y); end
        n_cmp++; if (m_bc !== 8'd0) begin n_mis++; $display("FAIL first_bounce: got %0d expected 0", m_bc); end
        step(11'd524, 11'd304);
        n_cmp++; if (m_tick !== 1'b0) begin n_mis++; $display("FAIL tick_width: got %b expected 0", m_tick); end
        n_cmp++; if ({m_r, m_g, m_b} !== 12'hFFF) begin n_mis++; $display("FAIL draw_topleft: got %h expected fff", {m_r, m_g, m_b}); end
        step(11'd588, 11'd304);
        n_cmp++; if ({m_r, m_g, m_b} !== 12'h000) begin n_mis++; $display("FAIL draw_right_out: got %h expected 000", {m_r, m_g, m_b}); end
    endtask

    task automatic test_draw_edges();
        step(11'd587, 11'd367);
        n_cmp++; if ({m_r, m_g, m_b} !== 12'hFFF) begin n_mis++; $display("FAIL draw_botright: got %h expected fff", {m_r, m_g, m_b}); end
        step(11'd524, 11'd368);
        n_cmp++; if ({m_r, m_g, m_b} !== 12'h000) begin n_mis++; $display("FAIL draw_below: got %h expected 000", {m_r, m_g, m_b}); end
        step(11'd523, 11'd304);
        n_cmp++; if ({m_r, m_g, m_b} !== 12'h000) begin n_mis++; $display("FAIL draw_left_out: got %h expected 000", {m_r, m_g, m_b}); end
        step(11'd1500, 11'd950);
        n_cmp++; if ({m_r, m_g, m_b} !== 12'h000) begin n_mis++; $display("FAIL draw_blank: got %h expected 000", {m_r, m_g, m_b}); end
    endtask

    task automatic test_edge_bounce();
        rst_n_e = 1'b1;
        step(11'd7, 11'd7);
        step(11'd0, 11'd900);
        n_cmp++; if (e_tick !== 1'b1) begin n_mis++; $display("FAIL edge_tick: got %b expected 1", e_tick); end
        n_cmp++; if ({dut_e.r_pos_x, dut_e.r_dx} !== {11'd1376, 1'b0}) begin
            n_mis++; $display("FAIL edge_pos_dx: got %0d/%b expected 1376/0", dut_e.r_pos_x, dut_e.r_dx); end
        n_cmp++; if (e_bc !== 8'd1) begin n_mis++; $display("FAIL edge_bounce: got %0d expected 1", e_bc); end
        step(11'd1376, 11'd304);
        n_cmp++; if ({e_r, e_g, e_b} !== 12'hF00) begin n_mis++; $display("FAIL edge_palette: got %h expected f00", {e_r, e_g, e_b}); end
        step(11'd1439, 11'd367);
        n_cmp++; if ({e_r, e_g, e_b} !== 12'hF00) begin n_mis++; $display("FAIL edge_last_px: got %h expected f00", {e_r, e_g, e_b}); end
        step(11'd1375, 11'd304);
        n_cmp++; if ({e_r, e_g, e_b} !== 12'h000) begin n_mis++; $display("FAIL edge_left_out: got %h expected 000", {e_r, e_g, e_b}); end
    endtask

    task automatic test_corner();
        rst_n_c = 1'b1;
        step(11'd9, 11'd9);
        step(11'd0, 11'd71);
        n_cmp++; if (m_tick !== 1'b0) begin n_mis++; $display("FAIL corner_not_main_tick: got %b expected 0", m_tick); end
        n_cmp++; if ({dut_c.r_pos_x, dut_c.r_pos_y, dut_c.r_dx, dut_c.r_dy, c_bc} !== {11'd6, 11'd7, 2'b00, 8'd1}) begin
            n_mis++; $display("FAIL corner_t1: got (%0d,%0d) dir %b%b bc %0d expected (6,7) dir 00 bc 1",
                              dut_c.r_pos_x, dut_c.r_pos_y, dut_c.r_dx, dut_c.r_dy, c_bc); end
        step(11'd0, 11'd71);
        n_cmp++; if ({dut_c.r_pos_x, dut_c.r_pos_y, c_bc} !== {11'd2, 11'd3, 8'd1}) begin
            n_mis++; $display("FAIL corner_t2: got (%0d,%0d) bc %0d expected (2,3) bc 1", dut_c.r_pos_x, dut_c.r_pos_y, c_bc); end
        step(11'd0, 11'd71);
        n_cmp++; if ({dut_c.r_pos_x, dut_c.r_pos_y, dut_c.r_dx, dut_c.r_dy, c_bc} !== {11'd0, 11'd0, 2'b11, 8'd2}) begin
            n_mis++; $display("FAIL corner_t3: got (%0d,%0d) dir %b%b bc %0d expected (0,0) dir 11 bc 2",
                              dut_c.r_pos_x, dut_c.r_pos_y, dut_c.r_dx, dut_c.r_dy, c_bc); end
        step(11'd0, 11'd0);
        n_cmp++; if ({c_r, c_g, c_b} !== 12'h0F0) begin n_mis++; $display("FAIL corner_palette: got %h expected 0f0", {c_r, c_g, c_b}); end
        step(11'd64, 11'd0);
        n_cmp++; if ({c_r, c_g, c_b} !== 12'h000) begin n_mis++; $display("FAIL corner_x_end: got %h expected 000", {c_r, c_g, c_b}); end
    endtask

    task automatic test_pause();
        pause = 1'b1;
        for (int i = 0; i < 3; i++) step(11'd9, 11'd9);
        for (int i = 0; i < 3; i++) begin
            step(11'd0, 11'd900);
            n_cmp++; if ({m_tick, e_tick} !== 2'b11) begin n_mis++; $display("FAIL pause_tick_%0d: got %b expected 11", i, {m_tick, e_tick}); end
            step(11'd9, 11'd9);
            n_cmp++; if (m_tick !== 1'b0) begin n_mis++; $display("FAIL pause_tick_low_%0d: got %b expected 0", i, m_tick); end
        end
        n_cmp++; if ({dut_m.r_pos_x, dut_m.r_pos_y, dut_m.r_dx, dut_m.r_dy, m_bc} !== {11'd528, 11'd308, 2'b11, 8'd0}) begin
            n_mis++; $display("FAIL pause_main_hold: got (%0d,%0d) bc %0d expected (528,308) bc 0", dut_m.r_pos_x, dut_m.r_pos_y, m_bc); end
        n_cmp++; if ({dut_e.r_pos_x, dut_e.r_dx, e_bc} !== {11'd1376, 1'b0, 8'd1}) begin
            n_mis++; $display("FAIL pause_edge_hold: got %0d bc %0d expected 1376 bc 1", dut_e.r_pos_x, e_bc); end
        step(11'd528, 11'd308);
        n_cmp++; if ({m_r, m_g, m_b} !== 12'hFFF) begin n_mis++; $display("FAIL pause_palette: got %h expected fff", {m_r, m_g, m_b}); end
        pause = 1'b0;
        for (int i = 0; i < 3; i++) step(11'd9, 11'd9);
        step(11'd0, 11'd900);
        n_cmp++; if ({dut_m.r_pos_x, dut_m.r_pos_y} !== {11'd532, 11'd312}) begin
            n_mis++; $display("FAIL unpause_move: got (%0d,%0d) expected (532,312)", dut_m.r_pos_x, dut_m.r_pos_y); end
    endtask

    task automatic test_reset_on_tick();
        for (int i = 0; i < 6; i++) step(11'd0, 11'd71);
        n_cmp++; if ({dut_c.r_pos_x, dut_c.r_pos_y, dut_c.r_dx, dut_c.r_dy, c_bc} !== {11'd6, 11'd7, 2'b00, 8'd5}) begin
            n_mis++; $display("FAIL five_bounces: got (%0d,%0d) bc %0d expected (6,7) bc 5", dut_c.r_pos_x, dut_c.r_pos_y, c_bc); end
        step(11'd0, 11'd71);
        rst_n_c = 1'b0;
        pause   = 1'b1;
        step(11'd0, 11'd71);
        rst_n_c = 1'b1;
        pause   = 1'b0;
        n_cmp++; if ({dut_c.r_pos_x, dut_c.r_pos_y, dut_c.r_dx, dut_c.r_dy} !== {11'd2, 11'd3, 2'b11}) begin
            n_mis++; $display("FAIL rst_tick_pos: got (%0d,%0d) dir %b%b expected (2,3) dir 11",
                              dut_c.r_pos_x, dut_c.r_pos_y, dut_c.r_dx, dut_c.r_dy); end
        n_cmp++; if ({c_bc, dut_c.r_palette, c_tick} !== {8'd0, 2'd0, 1'b0}) begin
            n_mis++; $display("FAIL rst_tick_cnt: got bc %0d pal %0d tick %b expected 0 0 0", c_bc, dut_c.r_palette, c_tick); end
        n_cmp++; if ({c_r, c_g, c_b, dut_c.r_pause_meta, dut_c.r_pause_sync} !== 14'd0) begin
            n_mis++; $display("FAIL rst_tick_draw_sync: got %h/%b%b expected 000/00",
                              {c_r, c_g, c_b}, dut_c.r_pause_meta, dut_c.r_pause_sync); end
        step(11'd9, 11'd9);
        step(11'd0, 11'd71);
        n_cmp++; if ({dut_c.r_pos_x, dut_c.r_pos_y, c_bc, c_tick} !== {11'd6, 11'd7, 8'd1, 1'b1}) begin
            n_mis++; $display("FAIL post_rst_update: got (%0d,%0d) bc %0d tick %b expected (6,7) bc 1 tick 1",
                              dut_c.r_pos_x, dut_c.r_pos_y, c_bc, c_tick); end
        step(11'd6, 11'd7);
        n_cmp++; if ({c_r, c_g, c_b} !== 12'hF00) begin n_mis++; $display("FAIL post_rst_palette: got %h expected f00", {c_r, c_g, c_b}); end
    endtask

    initial begin
        curr_x = '0;
        curr_y = '0;
        test_reset();
        test_first_tick();
        test_draw_edges();
        test_edge_bounce();
        test_corner();
        test_pause();
        test_reset_on_tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
